// File: rtl/data_responder.sv
// Single-outstanding memory responder: grants one request at a time and answers
// exactly LATENCY cycles later with read data or an error flag.
module data_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int NR_PORTS   = 3,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    localparam int IW        = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic [63:0]           address_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic                  data_we_i,
    input  logic [BW-1:0]         data_be_i,
    input  logic [1:0]            data_size_i,
    input  logic [IW-1:0]         id_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic [IW-1:0]         id_o,
    output logic                  err_o
);

    localparam int OFFW = $clog2(BW);
    localparam int AW   = $clog2(DEPTH);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(BW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic req_error(input logic [63:0] addr, input logic [1:0] size);
        logic [63:0] nbytes;
        nbytes = 64'd1 << size;
        return (addr >= ADDR_LIMIT) || ((addr & (nbytes - 64'd1)) != 64'd0) ||
               (nbytes > 64'(BW));
    endfunction

    state_e                  state_r;
    state_e                  state_next_s;
    logic [3:0]              cnt_r;
    logic [63:0]             lat_addr_r;
    logic [DATA_WIDTH-1:0]   lat_wdata_r;
    logic                    lat_we_r;
    logic [BW-1:0]           lat_be_r;
    logic [1:0]              lat_size_r;
    logic [IW-1:0]           lat_id_r;

    logic                    gnt_s;
    logic                    lat_err_s;
    logic [AW-1:0]           lat_idx_s;
    logic                    wr_en_s;
    logic [DATA_WIDTH-1:0]   wr_word_s;

    logic [63:0]             eff_addr_s;
    logic                    eff_we_s;
    logic [1:0]              eff_size_s;
    logic [IW-1:0]           eff_id_s;
    logic                    eff_err_s;
    logic [AW-1:0]           eff_idx_s;

    logic                    rvalid_d_s;
    logic                    err_d_s;
    logic [DATA_WIDTH-1:0]   rdata_d_s;
    logic [IW-1:0]           id_d_s;

    logic                    rvalid_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [IW-1:0]           id_r;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    // State register and latency counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            if (gnt_s) begin
                cnt_r <= 4'(LATENCY - 1);
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s) begin
                    state_next_s = (LATENCY == 1) ? RESP : BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Grant and next-cycle response values; with LATENCY 1 the response comes
    // straight from the inputs being granted, otherwise from the latched request.
    always_comb begin
        gnt_s = data_req_i & (state_r == IDLE) & ~rst_i;
        if (state_r == IDLE) begin
            eff_addr_s = address_i;
            eff_we_s   = data_we_i;
            eff_size_s = data_size_i;
            eff_id_s   = id_i;
        end else begin
            eff_addr_s = lat_addr_r;
            eff_we_s   = lat_we_r;
            eff_size_s = lat_size_r;
            eff_id_s   = lat_id_r;
        end
        eff_err_s  = req_error(eff_addr_s, eff_size_s);
        eff_idx_s  = eff_addr_s[OFFW +: AW];
        rvalid_d_s = (state_next_s == RESP);
        err_d_s    = rvalid_d_s & eff_err_s;
        id_d_s     = rvalid_d_s ? eff_id_s : {IW{1'b0}};
        if (rvalid_d_s && !eff_we_s && !eff_err_s) begin
            rdata_d_s = mem_r[eff_idx_s];
        end else begin
            rdata_d_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Request capture on grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_addr_r  <= 64'd0;
            lat_wdata_r <= {DATA_WIDTH{1'b0}};
            lat_we_r    <= 1'b0;
            lat_be_r    <= {BW{1'b0}};
            lat_size_r  <= 2'd0;
            lat_id_r    <= {IW{1'b0}};
        end else if (gnt_s) begin
            lat_addr_r  <= address_i;
            lat_wdata_r <= data_wdata_i;
            lat_we_r    <= data_we_i;
            lat_be_r    <= data_be_i;
            lat_size_r  <= data_size_i;
            lat_id_r    <= id_i;
        end else begin
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
            lat_we_r    <= lat_we_r;
            lat_be_r    <= lat_be_r;
            lat_size_r  <= lat_size_r;
            lat_id_r    <= lat_id_r;
        end
    end

    // Byte-merge of the latched write into the addressed word
    always_comb begin
        lat_err_s = req_error(lat_addr_r, lat_size_r);
        lat_idx_s = lat_addr_r[OFFW +: AW];
        wr_en_s   = (state_r == RESP) & lat_we_r & ~lat_err_s & ~rst_i;
        wr_word_s = mem_r[lat_idx_s];
        for (int b = 0; b < BW; b++) begin
            if (lat_be_r[b]) begin
                wr_word_s[8*b +: 8] = lat_wdata_r[8*b +: 8];
            end else begin
                wr_word_s[8*b +: 8] = mem_r[lat_idx_s][8*b +: 8];
            end
        end
    end

    // Storage array, intentionally left out of reset
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[lat_idx_s] <= wr_word_s;
        end
    end

    // Registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            id_r     <= {IW{1'b0}};
        end else begin
            rvalid_r <= rvalid_d_s;
            err_r    <= err_d_s;
            rdata_r  <= rdata_d_s;
            id_r     <= id_d_s;
        end
    end

    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_r;
    assign data_rdata_o  = rdata_r;
    assign id_o          = id_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_data_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 3) sharing request buses,
// each checked against a byte-level memory model.
module tb_data_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] address;
    logic [63:0] wdata;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
    logic [1:0]  id;

    logic        req      [3];
    logic        gnt_w    [3];
    logic        rvalid_w [3];
    logic [63:0] rdata_w  [3];
    logic [1:0]  id_w     [3];
    logic        err_w    [3];

    int checks   = 0;
    int failures = 0;

    logic [63:0] mref [3][256];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            data_responder #(
                .DATA_WIDTH(64), .NR_PORTS(3), .DEPTH(256), .LATENCY(g + 1)
            ) u_dut (
                .clk_i(clk), .rst_i(rst), .data_req_i(req[g]), .address_i(address),
                .data_wdata_i(wdata), .data_we_i(we), .data_be_i(be),
                .data_size_i(size), .id_i(id), .data_gnt_o(gnt_w[g]),
                .data_rvalid_o(rvalid_w[g]), .data_rdata_o(rdata_w[g]),
                .id_o(id_w[g]), .err_o(err_w[g])
            );
        end
    endgenerate

    function automatic logic model_err(input logic [63:0] a, input logic [1:0] sz);
        longint unsigned nbytes;
        nbytes = longint'(1) << sz;
        return (a >= 64'd2048) || ((a % nbytes) != 0) || (nbytes > 8);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a >> 3) & 64'd255);
    endfunction

    task automatic scramble();
        address = {$urandom(), $urandom()};
        wdata   = {$urandom(), $urandom()};
        we      = 1'($urandom());
        be      = 8'($urandom());
        size    = 2'($urandom());
        id      = 2'($urandom_range(0, 2));
    endtask

    // One full transaction on DUT d, checked against the model
    task automatic txn(input int d, input logic [63:0] a, input logic w, input logic [63:0] wd,
                       input logic [7:0] b, input logic [1:0] sz, input logic [1:0] i,
                       input string nm, output logic [63:0] got);
        int          k;
        int          widx;
        logic        e_err;
        logic [63:0] e_rd;
        widx  = word_of(a);
        e_err = model_err(a, sz);
        e_rd  = (!w && !e_err) ? mref[d][widx] : 64'd0;
        address = a; wdata = wd; we = w; be = b; size = sz; id = i; req[d] = 1'b1;
        #1;
        k = 0;
        while (gnt_w[d] !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (gnt_w[d] !== 1'b1) begin
            failures++; $display("FAIL %s_gnt: gnt=%b required 1", nm, gnt_w[d]);
        end
        @(negedge clk);
        req[d] = 1'b0;
        scramble();
        #1;
        k = 1;
        while (rvalid_w[d] !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (k != d + 1) begin
            failures++; $display("FAIL %s_latency: got %0d required %0d", nm, k, d + 1);
        end
        checks++;
        if (err_w[d] !== e_err) begin
            failures++; $display("FAIL %s_err: got %b required %b", nm, err_w[d], e_err);
        end
        checks++;
        if (rdata_w[d] !== e_rd) begin
            failures++; $display("FAIL %s_rdata: got %h required %h", nm, rdata_w[d], e_rd);
        end
        checks++;
        if (id_w[d] !== i) begin
            failures++; $display("FAIL %s_id: got %0d required %0d", nm, id_w[d], i);
        end
        got = rdata_w[d];
        if (w && !e_err) begin
            for (int j = 0; j < 8; j++) begin
                if (b[j]) mref[d][widx][8*j +: 8] = wd[8*j +: 8];
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid_w[d] !== 1'b0 || rdata_w[d] !== 64'd0 || err_w[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: rvalid=%b rdata=%h err=%b required 0/0/0", nm,
                     rvalid_w[d], rdata_w[d], err_w[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) req[d] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (gnt_w[d] !== 1'b0 || rvalid_w[d] !== 1'b0 || err_w[d] !== 1'b0 ||
                rdata_w[d] !== 64'd0 || id_w[d] !== 2'd0) begin
                failures++;
                $display("FAIL reset_dut%0d: gnt=%b rvalid=%b err=%b rdata=%h id=%0d required all 0",
                         d, gnt_w[d], rvalid_w[d], err_w[d], rdata_w[d], id_w[d]);
            end
        end
        for (int d = 0; d < 3; d++) req[d] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_init();
        logic [63:0] got;
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 32; w++) begin
                txn(d, 64'(w * 8), 1'b1, {$urandom(), $urandom()}, 8'hFF, 2'd3,
                    2'($urandom_range(0, 2)), "init", got);
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] got;
        logic [63:0] word0;
        txn(1, 64'h10, 1'b1, 64'h1122334455667788, 8'hFF, 2'd3, 2'd2, "wr_basic", got);
        txn(1, 64'h10, 1'b0, 64'd0, 8'hFF, 2'd3, 2'd0, "rd_basic", got);
        checks++;
        if (got !== 64'h1122334455667788) begin
            failures++; $display("FAIL rd_basic_value: got %h required 1122334455667788", got);
        end
        txn(1, 64'h20, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'd3, 2'd1, "wr_ones", got);
        txn(1, 64'h20, 1'b1, 64'd0, 8'h0F, 2'd3, 2'd1, "wr_be", got);
        txn(1, 64'h20, 1'b0, 64'd0, 8'hFF, 2'd3, 2'd1, "rd_be", got);
        checks++;
        if (got !== 64'hFFFFFFFF00000000) begin
            failures++; $display("FAIL be_merge_value: got %h required ffffffff00000000", got);
        end
        txn(1, 64'h13, 1'b0, 64'd0, 8'hFF, 2'd2, 2'd0, "rd_misalign", got);
        txn(1, 64'h0, 1'b0, 64'd0, 8'hFF, 2'd3, 2'd0, "rd_word0_before", word0);
        txn(1, 64'h800, 1'b1, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'd3, 2'd2, "wr_range", got);
        txn(1, 64'h0, 1'b0, 64'd0, 8'hFF, 2'd3, 2'd0, "rd_word0_after", got);
        checks++;
        if (got !== word0) begin
            failures++; $display("FAIL word0_unchanged: got %h required %h", got, word0);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [63:0] got;
        logic [63:0] a;
        logic [1:0]  sz;
        for (int t = 0; t < n; t++) begin
            sz = 2'($urandom());
            if ($urandom_range(0, 7) == 0) begin
                a = 64'h800 + 64'($urandom_range(0, 4095));
            end else if ($urandom_range(0, 3) == 0) begin
                a = 64'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
            end else begin
                a = 64'($urandom_range(0, 31) * 8) + (64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1));
            end
            txn(d, a, 1'($urandom()), {$urandom(), $urandom()}, 8'($urandom()), sz,
                2'($urandom_range(0, 2)), "random", got);
        end
    endtask

    // LATENCY 1 with the request held high: grant, respond, grant, ...
    task automatic test_back_to_back();
        logic        pending;
        logic        exp_gnt;
        logic [1:0]  pend_id;
        logic [63:0] pend_rd;
        int          dut_grants;
        pending = 1'b0; pend_id = 2'd0; pend_rd = 64'd0; dut_grants = 0;
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (rvalid_w[0] !== pending ||
                (pending && (id_w[0] !== pend_id || rdata_w[0] !== pend_rd || err_w[0] !== 1'b0))) begin
                failures++;
                $display("FAIL b2b_resp_c%0d: rvalid=%b id=%0d rdata=%h required %b/%0d/%h", c,
                         rvalid_w[0], id_w[0], rdata_w[0], pending, pend_id, pend_rd);
            end
            if (c == 10) break;
            address = 64'($urandom_range(0, 31) * 8);
            we = 1'b0; size = 2'd3; be = 8'hFF; wdata = {$urandom(), $urandom()};
            id = 2'($urandom_range(0, 2));
            req[0] = 1'b1;
            #1;
            exp_gnt = ~pending;
            checks++;
            if (gnt_w[0] !== exp_gnt) begin
                failures++; $display("FAIL b2b_gnt_c%0d: got %b required %b", c, gnt_w[0], exp_gnt);
            end
            if (gnt_w[0] === 1'b1) dut_grants++;
            pend_id = id;
            pend_rd = mref[0][word_of(address)];
            pending = exp_gnt;
            @(negedge clk);
            #1;
        end
        req[0] = 1'b0;
        checks++;
        if (dut_grants != 5) begin
            failures++; $display("FAIL b2b_grant_count: got %0d required 5", dut_grants);
        end
        @(negedge clk);
        #1;
    endtask

    // Reset during BUSY of a LATENCY 3 write: no response, no memory change
    task automatic test_reset_abort();
        logic [63:0] old;
        int          k;
        old = mref[2][6];
        address = 64'h30; we = 1'b1; wdata = ~old; be = 8'hFF; size = 2'd3; id = 2'd1;
        req[2] = 1'b1;
        #1;
        checks++;
        if (gnt_w[2] !== 1'b1) begin
            failures++; $display("FAIL abort_wr_gnt: got %b required 1", gnt_w[2]);
        end
        @(negedge clk);
        req[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        address = 64'h30; we = 1'b0; size = 2'd3; id = 2'd0; req[2] = 1'b1;
        #1;
        checks++;
        if (rvalid_w[2] !== 1'b0) begin
            failures++; $display("FAIL abort_no_rvalid: got %b required 0", rvalid_w[2]);
        end
        checks++;
        if (gnt_w[2] !== 1'b1) begin
            failures++; $display("FAIL abort_regrant: got %b required 1", gnt_w[2]);
        end
        @(negedge clk);
        req[2] = 1'b0;
        #1;
        k = 1;
        while (rvalid_w[2] !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (k != 3) begin
            failures++; $display("FAIL abort_rd_latency: got %0d required 3", k);
        end
        checks++;
        if (rdata_w[2] !== old || err_w[2] !== 1'b0) begin
            failures++;
            $display("FAIL abort_mem_unchanged: got %h err=%b required %h err=0", rdata_w[2], err_w[2], old);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; address = 64'd0; wdata = 64'd0; we = 1'b0; be = 8'd0; size = 2'd0; id = 2'd0;
        for (int d = 0; d < 3; d++) req[d] = 1'b0;
        @(negedge clk);
        test_reset();
        test_init();
        test_directed();
        test_random(1, 40);
        test_random(0, 30);
        test_random(2, 20);
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_responder.md
DATA_RESPONDER -- requirements
Module: data_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 64, data bus width in bits (multiple of 8); NR_PORTS, default 3, initiator-port count, sets ID width IW = $clog2(NR_PORTS); DEPTH, default 256, memory words (power of 2); LATENCY, default 2, cycles from grant to response (range 1..15).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  the single clock; everything on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i  in  1  request valid.
- address_i  in  64  byte address.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_size_i  in  2  access size, log2 bytes (0 = 1 B .. 3 = 8 B).
- id_i  in  IW  initiator port ID.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  one-cycle response strobe.
- data_rdata_o  out  DATA_WIDTH  read data.
- id_o  out  IW  ID of the response.
- err_o  out  1  response error flag, qualified by data_rvalid_o.

Function
REQ-003 State machine SHALL have three states: IDLE, BUSY and RESP.
REQ-004 data_gnt_o SHALL be combinational: data_req_i AND (state == IDLE); it SHALL be 0 in BUSY and RESP regardless of data_req_i.
REQ-005 On a grant cycle the block SHALL latch address, wdata, we, be, size and id, and load the latency counter with LATENCY-1.
- The next state SHALL be RESP if LATENCY == 1, otherwise BUSY.
REQ-006 In BUSY the counter SHALL decrement once per cycle; the state SHALL move to RESP in the cycle after the counter reaches 1.
- Grant at cycle T therefore gives data_rvalid_o at cycle T+LATENCY exactly.
REQ-007 In RESP, data_rvalid_o, id_o, data_rdata_o and err_o SHALL be driven for exactly one cycle, then the state SHALL return to IDLE.
- A new request SHALL NOT be granted in the RESP cycle; the earliest next grant is RESP+1.
REQ-008 Word index SHALL be address_i[$clog2(DATA_WIDTH/8) +: $clog2(DEPTH)].
REQ-009 A request SHALL be in error if either:
- address >= DEPTH*DATA_WIDTH/8, or
- address is not aligned to 2^size bytes, or
- 2^size > DATA_WIDTH/8.
REQ-010 Writes SHALL update only the bytes with be = 1, at the RESP cycle edge; an erroneous write SHALL modify nothing.
REQ-011 Read data SHALL be the full memory word at RESP; data_rdata_o SHALL be 0 for writes, for errors, and whenever data_rvalid_o = 0.
REQ-012 err_o SHALL be 1 only in an erroneous RESP cycle, otherwise 0.
- id_o SHALL hold the latched ID; it is don't-care outside RESP but SHALL be driven deterministically.
REQ-013 A read in the cycle after a write response to the same word SHALL return the written data (no hazard).
REQ-014 Changes to request inputs while BUSY or RESP SHALL have no effect; data_req_i held high while busy SHALL NOT produce a second grant.

Reset
REQ-015 While rst_i = 1 at a clock edge, the block SHALL reset:
- state = IDLE, counter = 0, latched request = 0;
- data_rvalid_o = 0, err_o = 0, data_rdata_o = 0, id_o = 0;
- data_gnt_o SHALL be 0 during reset.
REQ-016 Reset asserted during BUSY or RESP SHALL abort the transaction with no data_rvalid_o pulse.
- A write aborted before its RESP edge SHALL NOT modify memory.
REQ-017 Memory contents SHALL NOT be reset.

Verification
REQ-018 LATENCY = 2: write address 0x10, wdata 0x1122334455667788, be 0xFF, size 3, id 2 at cycle T -> gnt at T; rvalid, id_o = 2, err_o = 0 at T+2; a read of 0x10 then returns 0x1122334455667788.
REQ-019 Byte-enable merge: write 0xFFFFFFFFFFFFFFFF to 0x20, then write 0 with be 0x0F -> a read of 0x20 returns 0xFFFFFFFF00000000.
REQ-020 Errors:
- Read 0x13 with size 2 -> rvalid, err_o = 1, rdata 0.
- Write to 0x800 (DEPTH 256) -> err_o = 1, and a read of word 0 is unchanged.
REQ-021 Back-to-back: data_req_i held high for 10 cycles with LATENCY = 1 -> grants every 2 cycles; never two outstanding; each rvalid one cycle; id_o tracks id_i sampled at the grant.
REQ-022 Assert rst_i in the BUSY cycle after a write grant (LATENCY = 3) -> no rvalid; memory word unchanged; the next request is granted in the first cycle after rst_i deasserts.
